// File: rtl/hilbert_iq_multichannel_if.sv
// Sample/result bundle between the ADC tick domain and the time-multiplexed Hilbert IQ core.
interface hilbert_iq_multichannel_if #(
  parameter int NUM_BITS     = 24,
  parameter int COEFF_LENGTH = 13,
  parameter int NUM_CH       = 2
);
  logic                       tick_i;
  logic signed [NUM_BITS-1:0] signal_i    [NUM_CH];
  logic signed [NUM_BITS-1:0] ha_coeffs_i [COEFF_LENGTH];
  logic signed [NUM_BITS-1:0] sin_o       [NUM_CH];
  logic signed [NUM_BITS-1:0] cos_o       [NUM_CH];
  logic                       done_o;
  logic                       busy_o;
  logic                       overrun_o;

  modport master (output tick_i, signal_i, ha_coeffs_i,
                  input  sin_o, cos_o, done_o, busy_o, overrun_o);
  modport slave  (input  tick_i, signal_i, ha_coeffs_i,
                  output sin_o, cos_o, done_o, busy_o, overrun_o);
endinterface

// File: rtl/hilbert_iq_multichannel.sv
// Multichannel Hilbert IQ generator: one shared MAC walks every (channel, tap) pair per tick.
// Optional macro HILBERT_IQ_SATURATE_EN clamps cos_o instead of wrapping it.
module hilbert_iq_multichannel #(
  parameter int NUM_BITS     = 24,
  parameter int COEFF_LENGTH = 13,
  parameter int NUM_CH       = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  hilbert_iq_multichannel_if.slave    bus
);
  localparam int PROD_W = 2 * NUM_BITS;
  localparam int ACC_W  = PROD_W + $clog2(COEFF_LENGTH);
  localparam int D      = (COEFF_LENGTH - 1) / 2;
  localparam int KW     = $clog2(COEFF_LENGTH);
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(COEFF_LENGTH - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);
  localparam logic signed [ACC_W-1:0] HALF_LSB =
    {{(ACC_W-NUM_BITS+1){1'b0}}, 1'b1, {(NUM_BITS-2){1'b0}}};
`ifdef HILBERT_IQ_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-NUM_BITS+1){1'b0}}, {(NUM_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-NUM_BITS+1){1'b1}}, {(NUM_BITS-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, MAC = 2'd2, OUT = 2'd3} state_t;

  state_t                     state_q, state_d;
  logic [KW-1:0]              wp_q, k_q;
  logic [CW-1:0]              ch_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [NUM_BITS-1:0] buf_q [NUM_CH][COEFF_LENGTH];
  logic signed [NUM_BITS-1:0] smp_q [NUM_CH];
  logic signed [NUM_BITS-1:0] sin_q [NUM_CH];
  logic signed [NUM_BITS-1:0] cos_q [NUM_CH];
  logic                       done_q, busy_q, overrun_q;

  logic [KW-1:0]              wp_next_s, tap_s, sin_idx_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]    acc_sum_s, res_s;
  logic                       last_tap_s, last_ch_s;

  // Circular index (base - off) mod COEFF_LENGTH using a conditional add instead of a divider.
  function automatic logic [KW-1:0] tap_index(input logic [KW-1:0] base, input logic [KW-1:0] off);
    if (base >= off) begin
      tap_index = base - off;
    end else begin
      tap_index = base + KW'(COEFF_LENGTH) - off;
    end
  endfunction

  function automatic logic signed [NUM_BITS-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef HILBERT_IQ_SATURATE_EN
    if (v > SAT_MAX) begin
      narrow = SAT_MAX[NUM_BITS-1:0];
    end else if (v < SAT_MIN) begin
      narrow = SAT_MIN[NUM_BITS-1:0];
    end else begin
      narrow = v[NUM_BITS-1:0];
    end
`else
    narrow = v[NUM_BITS-1:0];
`endif
  endfunction

  // Tap addressing and the single shared multiply-accumulate.
  always_comb begin
    wp_next_s  = (wp_q == K_LAST) ? {KW{1'b0}} : wp_q + KW'(1);
    tap_s      = tap_index(wp_q, k_q);
    sin_idx_s  = tap_index(wp_q, KW'(D));
    prod_s     = bus.ha_coeffs_i[k_q] * buf_q[ch_q][tap_s];
    acc_sum_s  = acc_q + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    res_s      = (acc_sum_s + HALF_LSB) >>> (NUM_BITS - 1);
    last_tap_s = (k_q == K_LAST);
    last_ch_s  = (ch_q == CH_LAST);
  end

  // Next-state logic of the sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.tick_i) state_d = WRITE; else state_d = IDLE;
      WRITE:   state_d = MAC;
      MAC:     if (last_tap_s && last_ch_s) state_d = OUT; else state_d = MAC;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Sample buffers, MAC walk, result registers and status flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wp_q      <= {KW{1'b0}};
      k_q       <= {KW{1'b0}};
      ch_q      <= {CW{1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        smp_q[c] <= {NUM_BITS{1'b0}};
        sin_q[c] <= {NUM_BITS{1'b0}};
        cos_q[c] <= {NUM_BITS{1'b0}};
        for (int k = 0; k < COEFF_LENGTH; k++) buf_q[c][k] <= {NUM_BITS{1'b0}};
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.tick_i) begin
            for (int c = 0; c < NUM_CH; c++) smp_q[c] <= bus.signal_i[c];
          end
        end
        WRITE: begin
          // Newest sample lands at the advanced pointer so tap 0 reads wp itself.
          for (int c = 0; c < NUM_CH; c++) buf_q[c][wp_next_s] <= smp_q[c];
          wp_q  <= wp_next_s;
          acc_q <= {ACC_W{1'b0}};
          k_q   <= {KW{1'b0}};
          ch_q  <= {CW{1'b0}};
        end
        MAC: begin
          if (last_tap_s) begin
            cos_q[ch_q] <= narrow(res_s);
            sin_q[ch_q] <= buf_q[ch_q][sin_idx_s];
            acc_q       <= {ACC_W{1'b0}};
            k_q         <= {KW{1'b0}};
            ch_q        <= ch_q + CW'(1);
          end else begin
            acc_q <= acc_sum_s;
            k_q   <= k_q + KW'(1);
          end
        end
        default: begin
        end
      endcase

      done_q <= (state_q == MAC) && last_tap_s && last_ch_s;
      if ((state_q == IDLE) && bus.tick_i) busy_q <= 1'b1;
      else if (state_q == OUT)              busy_q <= 1'b0;
      else                                  busy_q <= busy_q;
      if (bus.tick_i && busy_q) overrun_q <= 1'b1;
      else                      overrun_q <= overrun_q;
    end
  end

  assign bus.sin_o     = sin_q;
  assign bus.cos_o     = cos_q;
  assign bus.done_o    = done_q;
  assign bus.busy_o    = busy_q;
  assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_hilbert_iq_multichannel.sv
// Randomized self-checking bench: windowed-sum reference model, done-time compare, pinned literals.
module tb_hilbert_iq_multichannel;
  localparam int LAT = 2 + 2 * 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilbert_iq_multichannel_if #(.NUM_BITS(24), .COEFF_LENGTH(5),  .NUM_CH(2)) bus   ();
  hilbert_iq_multichannel_if #(.NUM_BITS(24), .COEFF_LENGTH(13), .NUM_CH(2)) bus13 ();
  hilbert_iq_multichannel_if #(.NUM_BITS(24), .COEFF_LENGTH(5),  .NUM_CH(1)) bus1  ();

  hilbert_iq_multichannel #(.NUM_BITS(24), .COEFF_LENGTH(5),  .NUM_CH(2)) dut
    (.clk_i(clk), .reset_i(rst), .bus(bus));
  hilbert_iq_multichannel #(.NUM_BITS(24), .COEFF_LENGTH(13), .NUM_CH(2)) dut13
    (.clk_i(clk), .reset_i(rst), .bus(bus13));
  hilbert_iq_multichannel #(.NUM_BITS(24), .COEFF_LENGTH(5),  .NUM_CH(1)) dut1
    (.clk_i(clk), .reset_i(rst), .bus(bus1));

  typedef struct packed {
    logic [1:0][23:0] cos;
    logic [1:0][23:0] sin;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  exp_t   exp_q[$];
  longint h_m [5] = '{64'sh100000, 64'sh200000, 64'sd0, -64'sh200000, -64'sh100000};
  longint xh  [2][5];

  localparam logic [23:0] IMP_COS [7] = '{24'h080000, 24'h100000, 24'h000000, 24'hF00000,
                                          24'hF80000, 24'h000000, 24'h000000};
  localparam logic [23:0] IMP_SIN [7] = '{24'h000000, 24'h000000, 24'h400000, 24'h000000,
                                          24'h000000, 24'h000000, 24'h000000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] narrow24(input longint s);
    longint r;
    r = (s + 64'sd4194304) >>> 23;
`ifdef HILBERT_IQ_SATURATE_EN
    if (r > 64'sd8388607) r = 64'sd8388607;
    else if (r < -64'sd8388608) r = -64'sd8388608;
`endif
    return r[23:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) for (int k = 0; k < 5; k++) xh[c][k] = 0;
    exp_q.delete();
  endtask

  // cos[n] = sum h[k]*x[n-k], sin[n] = x[n-2], straight from the filter definition.
  task automatic model_push(input logic [23:0] s0, input logic [23:0] s1);
    exp_t   e;
    longint acc;
    for (int c = 0; c < 2; c++) begin
      for (int k = 4; k > 0; k--) xh[c][k] = xh[c][k-1];
      xh[c][0] = (c == 0) ? longint'($signed(s0)) : longint'($signed(s1));
      acc = 0;
      for (int k = 0; k < 5; k++) acc += h_m[k] * xh[c][k];
      e.cos[c] = narrow24(acc);
      e.sin[c] = 24'(xh[c][2]);
    end
    exp_q.push_back(e);
  endtask

  // Every done pulse of the main DUT is checked against the oldest model result.
  always @(negedge clk) begin
    if (!rst && bus.done_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        for (int c = 0; c < 2; c++) begin
          check($sformatf("cos_ch%0d", c), {40'd0, bus.cos_o[c][23:0]}, {40'd0, e.cos[c]});
          check($sformatf("sin_ch%0d", c), {40'd0, bus.sin_o[c][23:0]}, {40'd0, e.sin[c]});
        end
      end
    end
  end

  // Called at a negedge; tick is sampled by the following posedge (edge T).
  task automatic run_tick(input logic [23:0] s0, input logic [23:0] s1,
                          input int ovr_at, input int rst_at);
    int done_at  = 0;
    int busy_low = 0;
    bus.tick_i      = 1'b1;
    bus.signal_i[0] = s0;
    bus.signal_i[1] = s1;
    model_push(s0, s1);
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (j == 1) begin
        bus.tick_i      = 1'b0;
        bus.signal_i[0] = 24'($urandom);
        bus.signal_i[1] = 24'($urandom);
      end
      if (ovr_at != 0 && j == ovr_at)     bus.tick_i = 1'b1;
      if (ovr_at != 0 && j == ovr_at + 1) bus.tick_i = 1'b0;
      if (rst_at != 0 && j == rst_at) begin
        rst = 1'b1;
        model_clear();
      end
      if (rst_at != 0 && j == rst_at + 2) rst = 1'b0;
      if (bus.done_o && done_at == 0) done_at = j;
      if (rst_at == 0 && !bus.busy_o && busy_low == 0) begin
        busy_low = j;
        break;
      end
      if (rst_at != 0 && j == rst_at + 20) break;
    end
    if (rst_at == 0) begin
      check("done_latency", 64'(done_at), 64'(LAT));
      check("busy_fall", 64'(busy_low), 64'(LAT + 1));
    end else begin
      check("done_after_reset", 64'(done_at), 64'd0);
    end
  endtask

  task automatic impulse_run();
    for (int t = 0; t < 7; t++) begin
      run_tick((t == 0) ? 24'h400000 : 24'h000000, 24'h000000, 0, 0);
      check($sformatf("imp_cos0_t%0d", t), {40'd0, bus.cos_o[0][23:0]}, {40'd0, IMP_COS[t]});
      check($sformatf("imp_sin0_t%0d", t), {40'd0, bus.sin_o[0][23:0]}, {40'd0, IMP_SIN[t]});
      check($sformatf("imp_ch1_t%0d", t),
            {16'd0, bus.cos_o[1][23:0], bus.sin_o[1][23:0]}, 64'd0);
    end
  endtask

  initial begin
    longint x1 [5];
    longint acc;
    logic [23:0] exp1;
    int done_at, busy_low;

    rst = 1'b1;
    bus.tick_i = 1'b0; bus13.tick_i = 1'b0; bus1.tick_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.signal_i[c] = 24'd0; bus13.signal_i[c] = 24'd0;
    end
    bus1.signal_i[0] = 24'd0;
    for (int k = 0; k < 5; k++) begin
      bus.ha_coeffs_i[k]  = 24'(h_m[k]);
      bus1.ha_coeffs_i[k] = 24'h7FFFFF;
    end
    for (int k = 0; k < 13; k++) bus13.ha_coeffs_i[k] = 24'($urandom);
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_outputs", {16'd0, bus.cos_o[0][23:0], bus.sin_o[0][23:0]}, 64'd0);
    check("rst_outputs_ch1", {16'd0, bus.cos_o[1][23:0], bus.sin_o[1][23:0]}, 64'd0);
    check("rst_flags", {61'd0, bus.done_o, bus.busy_o, bus.overrun_o}, 64'd0);

    impulse_run();

    // Overrun: extra tick at T+6 is ignored; next tick at T+13 is accepted.
    run_tick(24'($urandom), 24'($urandom), 6, 0);
    check("overrun_set", 64'(bus.overrun_o), 64'd1);
    run_tick(24'($urandom), 24'($urandom), 0, 0);
    check("overrun_sticky", 64'(bus.overrun_o), 64'd1);

    // Reset at T+7 discards the computation and clears everything.
    run_tick(24'($urandom), 24'($urandom), 0, 7);
    check("reset_outputs", {16'd0, bus.cos_o[0][23:0], bus.sin_o[0][23:0]}, 64'd0);
    check("reset_outputs_ch1", {16'd0, bus.cos_o[1][23:0], bus.sin_o[1][23:0]}, 64'd0);
    check("reset_flags", {61'd0, bus.done_o, bus.busy_o, bus.overrun_o}, 64'd0);
    impulse_run();

    for (int t = 0; t < 40; t++) run_tick(24'($urandom), 24'($urandom), 0, 0);

    // Default parameters: done must land 28 clocks after the sampling edge.
    bus13.tick_i = 1'b1;
    bus13.signal_i[0] = 24'($urandom);
    bus13.signal_i[1] = 24'($urandom);
    done_at = 0; busy_low = 0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (j == 1) bus13.tick_i = 1'b0;
      if (bus13.done_o && done_at == 0) done_at = j;
      if (!bus13.busy_o) begin
        busy_low = j;
        break;
      end
    end
    check("default_latency", 64'(done_at), 64'd28);
    check("default_busy_fall", 64'(busy_low), 64'd29);

    // Single channel, all-max coefficients and samples: wrap vs clamp.
    for (int k = 0; k < 5; k++) x1[k] = 0;
    for (int t = 0; t < 5; t++) begin
      for (int k = 4; k > 0; k--) x1[k] = x1[k-1];
      x1[0] = 64'sh7FFFFF;
      acc = 0;
      for (int k = 0; k < 5; k++) acc += 64'sh7FFFFF * x1[k];
      exp1 = narrow24(acc);
      bus1.tick_i = 1'b1;
      bus1.signal_i[0] = 24'h7FFFFF;
      done_at = 0;
      for (int j = 1; j <= 40; j++) begin
        @(negedge clk);
        if (j == 1) bus1.tick_i = 1'b0;
        if (bus1.done_o) begin
          done_at = j;
          break;
        end
      end
      check($sformatf("sat_latency_t%0d", t), 64'(done_at), 64'd7);
      check($sformatf("sat_cos_t%0d", t), {40'd0, bus1.cos_o[0][23:0]}, {40'd0, exp1});
      @(negedge clk);
    end
`ifdef HILBERT_IQ_SATURATE_EN
    check("sat_pinned", {40'd0, bus1.cos_o[0][23:0]}, 64'h7FFFFF);
`else
    check("wrap_pinned", {40'd0, bus1.cos_o[0][23:0]}, 64'h7FFFF6);
`endif

    repeat (5) @(negedge clk);
    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
